// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage hazard bundle: decode fields, WB write-back bus, drain handshake, status.
// Latency: pure wiring, no storage.
// Backpressure: ds_ready_go from the controller gates decode's hand-off to execute.
interface id_hazard_ctrl_if;
  logic        ds_valid;
  logic        ds_src1_re;
  logic [4:0]  ds_src1_addr;
  logic        ds_src2_re;
  logic [4:0]  ds_src2_addr;
  logic        ds_gr_we;
  logic [4:0]  ds_dest;
  logic        es_allowin;
  logic        ws_rf_we;
  logic [4:0]  ws_rf_waddr;
  logic        drain_req;
  logic        ds_ready_go;
  logic        drain_ack;
  logic [31:0] busy_vec;
  logic [31:0] perf_stall_cnt;

  // Pipeline side: drives decode/WB fields, observes the controller.
  modport master (
    output ds_valid, ds_src1_re, ds_src1_addr, ds_src2_re, ds_src2_addr,
           ds_gr_we, ds_dest, es_allowin, ws_rf_we, ws_rf_waddr, drain_req,
    input  ds_ready_go, drain_ack, busy_vec, perf_stall_cnt
  );

  // Controller side.
  modport slave (
    input  ds_valid, ds_src1_re, ds_src1_addr, ds_src2_re, ds_src2_addr,
           ds_gr_we, ds_dest, es_allowin, ws_rf_we, ws_rf_waddr, drain_req,
    output ds_ready_go, drain_ack, busy_vec, perf_stall_cnt
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Register scoreboard + issue/drain controller for decode; optional stall counter under HAZ_PERF_EN.
// Latency: ds_ready_go combinational from registered counters; busy_vec/drain_ack registered (1 cycle).
// Backpressure: holds ds_ready_go low on RAW hazards, saturated dest counters, or while draining.
module id_hazard_ctrl #(
  parameter int CNT_W = 2
) (
  input logic          clk,
  input logic          resetn,
  id_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [31:0]      inc_v, dec_v;
  logic [31:0]      busy_d, busy_q;
  logic             src1_haz, src2_haz, dest_sat, blocked;
  logic             ready_go, ds_fire, all_zero;

  // Hazard detection against the registered counters; no WB bypass, since the
  // regfile write lands at the edge and is readable only the following cycle.
  always_comb begin
    src1_haz = hz.ds_src1_re && (cnt_q[hz.ds_src1_addr] != '0);
    src2_haz = hz.ds_src2_re && (cnt_q[hz.ds_src2_addr] != '0);
    dest_sat = hz.ds_gr_we   && (&cnt_q[hz.ds_dest]);
    blocked  = (state_q != ST_IDLE);
    ready_go = !(src1_haz || src2_haz || dest_sat || blocked);
    ds_fire  = hz.ds_valid && ready_go && hz.es_allowin;
  end

  assign hz.ds_ready_go = ready_go;

  // Per-register increment (issued writer) and decrement (WB write) requests.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 1; i < 32; i++) begin
      inc_v[i] = ds_fire && hz.ds_gr_we && (hz.ds_dest == 5'(i));
      dec_v[i] = hz.ws_rf_we && (hz.ws_rf_waddr == 5'(i));
    end
  end

  // Next counter values: simultaneous inc/dec cancel, decrement of an idle
  // register is a spurious WB and is dropped. r0 is never tracked.
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i == 0) begin
        cnt_d[i] = '0;
      end else if (inc_v[i] && !dec_v[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_v[i] && !inc_v[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      busy_d[i] = (cnt_d[i] != '0);
    end
  end

  // Counter and busy-vector registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
      busy_q <= busy_d;
    end
  end

  assign hz.busy_vec = busy_q;
  assign all_zero    = ~|busy_q;

  // Drain FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Drain FSM next state: a dropped request always wins and returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (hz.drain_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!hz.drain_req)  state_d = ST_IDLE;
        else if (all_zero)  state_d = ST_DONE;
      end
      ST_DONE:  if (!hz.drain_req) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign hz.drain_ack = (state_q == ST_DONE);

`ifdef HAZ_PERF_EN
  logic [31:0] stall_q;

  // Count cycles where decode holds a valid instruction that cannot go.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                       stall_q <= '0;
    else if (hz.ds_valid && !ready_go) stall_q <= stall_q + 32'd1;
  end

  assign hz.perf_stall_cnt = stall_q;
`else
  assign hz.perf_stall_cnt = '0;
`endif

endmodule
